shoe_dealer: RTL and testbench
==============================

# shoe_dealer

Card source that feeds the baccarat round controller. Models a shoe of NUM_DECKS standard decks and deals ranks without replacement. A maximal-length LFSR picks each card, and the next card is always pre-drawn and held stable, so the controller can latch it on the same slow_clock edge that it asserts any load_* strobe. The shoe reports empty when exhausted and can be reshuffled between rounds.

## Interface
- NUM_DECKS, default 4: number of decks in the shoe; legal range 1..4, so the shoe holds at most 208 cards and fits in 8 bits.
- slow_clock  in  1  sole clock; all state updates on its rising edge.
- resetb  in  1  synchronous, active-low reset.
- deal  in  1  one-cycle request; consumes the held card. Driven by the OR of the six load_* strobes.
- reshuffle  in  1  one-cycle request; refills the shoe to full.
- new_card  out  4  held card rank: 1 = Ace, 2..10 = pips, 11/12/13 = J/Q/K. Value is 0 when nothing is held.
- card_valid  out  1  new_card holds a reserved card.
- cards_left  out  8  cards still in the shoe, excluding the held card.
- shoe_empty  out  1  (cards_left == 0) && !card_valid.
- deal_error  out  1  sticky; set when deal arrives while card_valid = 0.

## Operation
- Storage:
  - Per-rank counters count[1..13], 5 bits each, reset to 4*NUM_DECKS.
  - cards_left register, reset to 52*NUM_DECKS.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1.
  - Each cycle: shift left, bit0 <= l[15]^l[13]^l[12]^l[10].
  - Held at seed while resetb = 0; advances every cycle otherwise, in every state.
  - Candidate rank cand = lfsr[3:0].
- States: FILL, READY, EMPTY. Reset state is FILL.
- FILL:
  - If cand is in 1..13 and count[cand] != 0: new_card <= cand, count[cand]--, cards_left--, card_valid <= 1, go to READY. The card is reserved at this point.
  - Otherwise stay in FILL and retry on the next cycle.
- READY, deal = 1:
  - card_valid <= 0, new_card <= 0.
  - Next state is FILL if cards_left != 0, else EMPTY.
- EMPTY:
  - card_valid = 0, shoe_empty = 1.
  - deal sets deal_error.
  - Only reshuffle or reset leaves this state.
- deal while card_valid = 0 (in FILL or EMPTY): deal_error <= 1; no other effect.
- reshuffle, any state:
  - All counts reload to 4*NUM_DECKS; cards_left reloads to 52*NUM_DECKS.
  - Held card is discarded: card_valid <= 0, new_card <= 0.
  - deal_error <= 0; next state FILL; LFSR is not reseeded.
- Simultaneous events:
  - reshuffle with deal in the same cycle: reshuffle wins and the deal is ignored, with no error.
  - resetb = 0 overrides everything.

## Timing
- Reset values: new_card = 0, card_valid = 0, cards_left = 52*NUM_DECKS, shoe_empty = 0, deal_error = 0, state FILL, LFSR = 16'hACE1.
- First edge after reset release: cand = 1 (from 0xACE1), so new_card = 1 and card_valid = 1 appear after that edge. cards_left is then 207 for NUM_DECKS = 4.
- Deal to next card: at least 2 edges (consume edge, then one or more FILL edges).
  - Retries are unbounded in principle but end within 65535 cycles, because the LFSR is maximal length.
  - Bench timeout: 70000 cycles.
- new_card is stable for the entire time card_valid = 1.
- Reset mid-FILL or mid-READY: all outputs return to reset values on that edge.

## Structure
- Shared package baccarat_pkg holds:
  - dealer_state_t enum {FILL, READY, EMPTY}.
  - LFSR_SEED = 16'hACE1.
  - RANK_ACE = 1, RANK_KING = 13.
  - CARDS_PER_DECK = 52, PER_RANK_PER_DECK = 4.
- One sub-module, lfsr16 (ports: clock, reset, q[15:0]), instantiated once. All other logic stays in shoe_dealer.

## Test plan
- Reset, then release: after edge 1, new_card = 1, card_valid = 1, cards_left = 207, shoe_empty = 0, deal_error = 0.
- NUM_DECKS = 4, deal 208 cards, each deal issued only when card_valid = 1:
  - Every rank appears exactly 16 times and no value 0 or 14..15 is ever dealt.
  - Afterwards cards_left = 0, shoe_empty = 1, state EMPTY, deal_error = 0.
- Pulse deal on the cycle right after a consuming deal (card_valid = 0): deal_error = 1 and stays set; the count histogram is unaffected.
- After 10 deals, pulse reshuffle together with deal:
  - Next cycle: cards_left = 208, card_valid = 0, deal_error = 0.
  - card_valid returns within the timeout.
  - A full 208-card drain still yields 16 of each rank.
- Assert resetb = 0 for 1 cycle mid-drain: all outputs take reset values, and the first card after release is again 1.
- NUM_DECKS = 1: 52 deals give 4 of each rank, then shoe_empty = 1. A deal in EMPTY sets deal_error.

Source files
------------

// File: rtl/baccarat_pkg.sv
// +----------------------------------------------------------------------+
// | baccarat_pkg : shared types and constants for the baccarat card path |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package baccarat_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    EMPTY = 2'd2
  } dealer_state_t;

  localparam logic [15:0] LFSR_SEED         = 16'hACE1;
  localparam logic [3:0]  RANK_ACE          = 4'd1;
  localparam logic [3:0]  RANK_KING         = 4'd13;
  localparam int          CARDS_PER_DECK    = 52;
  localparam int          PER_RANK_PER_DECK = 4;

  function automatic logic rank_is_legal(input logic [3:0] rank);
    return (rank >= RANK_ACE) && (rank <= RANK_KING);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// +----------------------------------------------------------------------+
// | lfsr16 : 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, sync reset     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module lfsr16
  import baccarat_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        feedback;

  assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d   = {lfsr_q[14:0], feedback};

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/shoe_dealer.sv
// +----------------------------------------------------------------------+
// | shoe_dealer : multi-deck shoe dealing ranks without replacement,     |
// |               next card always pre-drawn and held. rev 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module shoe_dealer
  import baccarat_pkg::*;
#(
  parameter int NUM_DECKS = 4
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       deal,
  input  logic       reshuffle,
  output logic [3:0] new_card,
  output logic       card_valid,
  output logic [7:0] cards_left,
  output logic       shoe_empty,
  output logic       deal_error
);

  localparam int         R_LO      = int'(RANK_ACE);
  localparam int         R_HI      = int'(RANK_KING);
  localparam logic [4:0] FULL_RANK = 5'(PER_RANK_PER_DECK * NUM_DECKS);
  localparam logic [7:0] FULL_SHOE = 8'(CARDS_PER_DECK * NUM_DECKS);

  dealer_state_t state_q, state_d;
  logic [3:0]    new_card_q, new_card_d;
  logic          card_valid_q, card_valid_d;
  logic [7:0]    cards_left_q, cards_left_d;
  logic          deal_error_q, deal_error_d;
  logic [4:0]    count_q [R_LO:R_HI];
  logic [4:0]    count_d [R_LO:R_HI];

  logic [15:0]   lfsr;
  logic [3:0]    cand;
  logic          cand_avail;
  logic          lfsr_hi_unused;

  lfsr16 u_lfsr (
    .clock (slow_clock),
    .reset (!resetb),
    .q     (lfsr)
  );

  assign cand           = lfsr[3:0];
  assign lfsr_hi_unused = ^lfsr[15:4];

  // A candidate is usable only if it names a real rank with cards remaining.
  always_comb begin
    cand_avail = 1'b0;
    for (int r = R_LO; r <= R_HI; r++) begin
      if (rank_is_legal(cand) && (cand == 4'(r)) && (count_q[r] != 5'd0)) begin
        cand_avail = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    new_card_d   = new_card_q;
    card_valid_d = card_valid_q;
    cards_left_d = cards_left_q;
    deal_error_d = deal_error_q;
    count_d      = count_q;

    if (reshuffle) begin
      for (int r = R_LO; r <= R_HI; r++) begin
        count_d[r] = FULL_RANK;
      end
      cards_left_d = FULL_SHOE;
      card_valid_d = 1'b0;
      new_card_d   = 4'd0;
      deal_error_d = 1'b0;
      state_d      = FILL;
    end else begin
      case (state_q)
        FILL: begin
          if (deal) begin
            deal_error_d = 1'b1;
          end
          if (cand_avail) begin
            for (int r = R_LO; r <= R_HI; r++) begin
              if (cand == 4'(r)) begin
                count_d[r] = count_q[r] - 5'd1;
              end
            end
            new_card_d   = cand;
            card_valid_d = 1'b1;
            cards_left_d = cards_left_q - 8'd1;
            state_d      = READY;
          end
        end
        READY: begin
          if (deal) begin
            card_valid_d = 1'b0;
            new_card_d   = 4'd0;
            state_d      = (cards_left_q != 8'd0) ? FILL : EMPTY;
          end
        end
        EMPTY: begin
          if (deal) begin
            deal_error_d = 1'b1;
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q      <= FILL;
      new_card_q   <= 4'd0;
      card_valid_q <= 1'b0;
      cards_left_q <= FULL_SHOE;
      deal_error_q <= 1'b0;
      count_q      <= '{default: FULL_RANK};
    end else begin
      state_q      <= state_d;
      new_card_q   <= new_card_d;
      card_valid_q <= card_valid_d;
      cards_left_q <= cards_left_d;
      deal_error_q <= deal_error_d;
      count_q      <= count_d;
    end
  end

  assign new_card   = new_card_q;
  assign card_valid = card_valid_q;
  assign cards_left = cards_left_q;
  assign shoe_empty = (cards_left_q == 8'd0) && !card_valid_q;
  assign deal_error = deal_error_q;

endmodule

`default_nettype wire

// File: tb/tb_shoe_dealer.sv
// +----------------------------------------------------------------------+
// | tb_shoe_dealer : directed table plus drain sequences, 4- and 1-deck  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_shoe_dealer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rb4 = 1'b0;
  logic rb1 = 1'b0;
  logic deal = 1'b0;
  logic resh = 1'b0;
  logic sel = 1'b0;

  logic [3:0] c4, c1;
  logic       v4, v1, e4, e1, er4, er1;
  logic [7:0] l4, l1;

  shoe_dealer #(.NUM_DECKS(4)) dut4 (
    .slow_clock (clk),
    .resetb     (rb4),
    .deal       (deal),
    .reshuffle  (resh),
    .new_card   (c4),
    .card_valid (v4),
    .cards_left (l4),
    .shoe_empty (e4),
    .deal_error (er4)
  );

  shoe_dealer #(.NUM_DECKS(1)) dut1 (
    .slow_clock (clk),
    .resetb     (rb1),
    .deal       (deal),
    .reshuffle  (resh),
    .new_card   (c1),
    .card_valid (v1),
    .cards_left (l1),
    .shoe_empty (e1),
    .deal_error (er1)
  );

  logic [3:0] o_card;
  logic       o_valid, o_empty, o_err;
  logic [7:0] o_left;
  assign o_card  = sel ? c1  : c4;
  assign o_valid = sel ? v1  : v4;
  assign o_left  = sel ? l1  : l4;
  assign o_empty = sel ? e1  : e4;
  assign o_err   = sel ? er1 : er4;

  typedef struct {
    logic       rb;
    logic       deal;
    logic       resh;
    logic [3:0] card;
    logic       valid;
    logic [7:0] left;
    logic       empty;
    logic       err;
  } vec_t;

  vec_t vt [13];
  int   passed = 0;
  int   total = 0;
  int   hist [16];
  int   since_refill = 0;
  int   shoe_size = 208;
  bit   aborted = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic chk_outputs(input string tag, input int card, input int valid,
                             input int left, input int empty, input int err);
    chk({tag, ".new_card"},   int'(o_card),  card);
    chk({tag, ".card_valid"}, int'(o_valid), valid);
    chk({tag, ".cards_left"}, int'(o_left),  left);
    chk({tag, ".shoe_empty"}, int'(o_empty), empty);
    chk({tag, ".deal_error"}, int'(o_err),   err);
  endtask

  task automatic clear_hist();
    for (int r = 0; r < 16; r++) hist[r] = 0;
    since_refill = 0;
  endtask

  task automatic check_hist(input int expn);
    for (int r = 1; r <= 13; r++) begin
      chk($sformatf("hist_rank%0d", r), hist[r], expn);
    end
  endtask

  // Entered and left at a negedge; on return the last consuming edge has passed.
  task automatic deal_cards(input int n);
    int got = 0;
    int waitc = 0;
    while (got < n && !aborted) begin
      @(negedge clk);
      if (o_valid) begin
        chk("rank_range", int'(o_card >= 4'd1 && o_card <= 4'd13), 1);
        chk("left_while_held", int'(o_left), shoe_size - since_refill - 1);
        hist[o_card]++;
        since_refill++;
        got++;
        waitc = 0;
        deal = 1'b1;
      end else begin
        deal = 1'b0;
        waitc++;
        if (waitc > 70000) begin
          chk("deal_timeout", 0, 1);
          aborted = 1'b1;
        end
      end
    end
    @(negedge clk);
    deal = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!o_valid && n < 70000 && !aborted) begin
      @(negedge clk);
      n++;
    end
    chk("valid_within_timeout", int'(o_valid), 1);
    if (!o_valid) aborted = 1'b1;
  endtask

  initial begin
    int left_before;
    int valid_now;

    //                rb    deal  resh  card   v     left    empty err
    vt[0]  = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 8'd208, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 8'd208, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 4'd1,  1'b1, 8'd207, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 4'd1,  1'b1, 8'd207, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 8'd207, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 8'd207, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 8'd207, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 4'd12, 1'b1, 8'd206, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 4'd12, 1'b1, 8'd206, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 4'd0,  1'b0, 8'd208, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 4'd4,  1'b1, 8'd207, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 8'd208, 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b0, 1'b0, 4'd1,  1'b1, 8'd207, 1'b0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      rb4  = vt[i].rb;
      deal = vt[i].deal;
      resh = vt[i].resh;
      @(negedge clk);
      chk_outputs($sformatf("vec%0d", i), int'(vt[i].card), int'(vt[i].valid),
                  int'(vt[i].left), int'(vt[i].empty), int'(vt[i].err));
    end
    deal = 1'b0;
    resh = 1'b0;

    // Full drain of the 4-deck shoe, starting with the Ace already held.
    shoe_size = 208;
    clear_hist();
    deal_cards(208);
    check_hist(16);
    chk_outputs("drained4", 0, 0, 0, 1, 0);

    deal = 1'b1;
    @(negedge clk);
    deal = 1'b0;
    chk("empty_deal.deal_error", int'(o_err), 1);
    chk("empty_deal.shoe_empty", int'(o_empty), 1);

    resh = 1'b1;
    @(negedge clk);
    resh = 1'b0;
    chk_outputs("reshuffled", 0, 0, 208, 0, 0);
    clear_hist();

    // Deal right behind a consume, with no card held, must only flag an error.
    deal_cards(5);
    left_before = int'(o_left);
    deal = 1'b1;
    @(negedge clk);
    deal = 1'b0;
    valid_now = int'(o_valid);
    chk("early_deal.deal_error", int'(o_err), 1);
    chk("early_deal.cards_left", int'(o_left), left_before - valid_now);
    deal_cards(5);
    chk("early_deal.sticky", int'(o_err), 1);

    wait_valid();
    deal = 1'b1;
    resh = 1'b1;
    @(negedge clk);
    deal = 1'b0;
    resh = 1'b0;
    chk_outputs("resh_with_deal", 0, 0, 208, 0, 0);
    clear_hist();
    wait_valid();
    deal_cards(208);
    check_hist(16);
    chk_outputs("drained4b", 0, 0, 0, 1, 0);

    resh = 1'b1;
    @(negedge clk);
    resh = 1'b0;
    clear_hist();
    deal_cards(50);
    rb4 = 1'b0;
    @(negedge clk);
    chk_outputs("mid_reset", 0, 0, 208, 0, 0);
    rb4 = 1'b1;
    @(negedge clk);
    chk_outputs("after_reset", 1, 1, 207, 0, 0);

    // Single-deck shoe; the 4-deck instance is parked in reset.
    rb4 = 1'b0;
    sel = 1'b1;
    rb1 = 1'b1;
    @(negedge clk);
    chk_outputs("d1_first", 1, 1, 51, 0, 0);
    shoe_size = 52;
    clear_hist();
    deal_cards(52);
    check_hist(4);
    chk_outputs("d1_drained", 0, 0, 0, 1, 0);
    deal = 1'b1;
    @(negedge clk);
    deal = 1'b0;
    chk("d1_empty_deal.deal_error", int'(o_err), 1);
    chk("d1_empty_deal.shoe_empty", int'(o_empty), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
